// File: rtl/alu_mul_seq.sv
// Iterative 16x16 shift-and-add multiply sequencer that owns the execute-stage ALU input mux.
// While idle, the pipeline ALU controls pass straight through. A multiply request
// takes the ALU for one add per cycle and stalls the pipeline until the product is ready.
// Optional feature macro: MUL_EARLY_TERM_EN - finish as soon as no multiplier bits remain.
module alu_mul_seq #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CNT_W   = 4,
    parameter logic [4:0]  ADD_OPC = 5'b01000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] pipe_A,
    input  logic [WIDTH-1:0] pipe_B,
    input  logic [4:0]       pipe_Op,
    input  logic [1:0]       pipe_sub_op,
    input  logic             pipe_Cin,
    input  logic             pipe_nA,
    input  logic             pipe_nB,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [4:0]       alu_Op,
    output logic [1:0]       alu_sub_op,
    output logic             alu_Cin,
    output logic             alu_nA,
    output logic             alu_nB,
    input  logic [WIDTH-1:0] alu_Out,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               last_step_c;

    // Final add of the sequence: all iterations used, or (optionally) no multiplier bits left
    always_comb begin
        last_step_c = (cnt == CNT_W'(WIDTH - 1));
`ifdef MUL_EARLY_TERM_EN
        if ((mplier >> 1) == '0) begin
            last_step_c = 1'b1;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and ALU input mux: pipeline pass-through except while busy
    always_comb begin
        state_next = state;
        alu_A      = pipe_A;
        alu_B      = pipe_B;
        alu_Op     = pipe_Op;
        alu_sub_op = pipe_sub_op;
        alu_Cin    = pipe_Cin;
        alu_nA     = pipe_nA;
        alu_nB     = pipe_nB;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                alu_A      = acc;
                alu_B      = mplier[0] ? mcand : '0;
                alu_Op     = ADD_OPC;
                alu_sub_op = 2'b00;
                alu_Cin    = 1'b0;
                alu_nA     = 1'b0;
                alu_nB     = 1'b0;
                if (last_step_c) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            stall  <= 1'b0;
        end else begin
            done  <= 1'b0;
            stall <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= opA;
                        mplier <= opB;
                        cnt    <= '0;
                        stall  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    acc    <= alu_Out;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_step_c) begin
                        result <= alu_Out;
                        done   <= 1'b1;
                    end else begin
                        stall  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a small ALU model closing the loop.
module tb_alu_mul_seq;

    localparam logic [4:0] ADD_OPC  = 5'b01000;
    localparam logic [4:0] PIPE_OPC = 5'b01011;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] opA, opB;
    logic [15:0] pipe_A, pipe_B;
    logic [4:0]  pipe_Op;
    logic [1:0]  pipe_sub_op;
    logic        pipe_Cin, pipe_nA, pipe_nB;
    logic [15:0] alu_A, alu_B;
    logic [4:0]  alu_Op;
    logic [1:0]  alu_sub_op;
    logic        alu_Cin, alu_nA, alu_nB;
    logic [15:0] alu_Out;
    logic        stall, done;
    logic [15:0] result;
    logic [15:0] a_eff, b_eff;

    int checks = 0;
    int errors = 0;

    alu_mul_seq dut (
        .clk(clk), .rst(rst), .start(start), .opA(opA), .opB(opB),
        .pipe_A(pipe_A), .pipe_B(pipe_B), .pipe_Op(pipe_Op), .pipe_sub_op(pipe_sub_op),
        .pipe_Cin(pipe_Cin), .pipe_nA(pipe_nA), .pipe_nB(pipe_nB),
        .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op), .alu_sub_op(alu_sub_op),
        .alu_Cin(alu_Cin), .alu_nA(alu_nA), .alu_nB(alu_nB),
        .alu_Out(alu_Out), .stall(stall), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: add path for ADD_OPC, something different otherwise
    always_comb begin
        a_eff = alu_nA ? ~alu_A : alu_A;
        b_eff = alu_nB ? ~alu_B : alu_B;
        if (alu_Op == ADD_OPC) alu_Out = a_eff + b_eff + {15'b0, alu_Cin};
        else                   alu_Out = a_eff ^ b_eff;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Cycle of the done pulse, counted from the start edge
    function automatic int exp_lat(input logic [15:0] b);
`ifdef MUL_EARLY_TERM_EN
        int n = 0;
        for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
        return 1 + ((n < 1) ? 1 : n);
`else
        return 17;
`endif
    endfunction

    function automatic logic [15:0] prod(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        return p[15:0];
    endfunction

    // One multiply; optionally re-pulse start with other operands in busy cycle re_at
    task automatic mul_op(input logic [15:0] a, input logic [15:0] b, input int re_at, input string nm);
        int cyc;
        logic [31:0] mask;
        logic [15:0] exp_r;
        exp_r = prod(a, b);
        @(negedge clk);
        opA = a; opB = b; start = 1'b1; pipe_Op = PIPE_OPC;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            mask = (32'd1 << (cyc - 1)) - 32'd1;
            chk({nm, " busy_stall"}, 32'(stall), 32'd1);
            chk({nm, " busy_op"}, 32'(alu_Op), 32'(ADD_OPC));
            chk({nm, " partial"}, 32'(alu_A), 32'(prod(a, b & mask[15:0])));
            if (cyc == re_at) begin
                opA = 16'h0009; opB = 16'h0009; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({nm, " latency"}, 32'(cyc), 32'(exp_lat(b)));
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " result"}, 32'(result), 32'(exp_r));
        chk({nm, " done_stall"}, 32'(stall), 32'd0);
        chk({nm, " done_passthru"}, 32'(alu_Op), 32'(PIPE_OPC));
        @(negedge clk);
        chk({nm, " done_pulse"}, 32'(done), 32'd0);
        chk({nm, " held"}, 32'(result), 32'(exp_r));
        chk({nm, " idle_stall"}, 32'(stall), 32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] pa;
        logic [15:0] pb;
        logic [4:0]  op;
        logic [1:0]  sub;
        logic [2:0]  ctl;
    } pt_t;

    vec_t vecs[8];
    pt_t  pts[3];

    initial begin
        vecs[0] = '{16'h0003, 16'h0005, 16'h000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0001};
        vecs[2] = '{16'h0100, 16'h0100, 16'h0000};
        vecs[3] = '{16'h0007, 16'h0002, 16'h000E};
        vecs[4] = '{16'h1234, 16'h0000, 16'h0000};
        vecs[5] = '{16'h0000, 16'h1234, 16'h0000};
        vecs[6] = '{16'h0001, 16'hFFFF, 16'hFFFF};
        vecs[7] = '{16'h1234, 16'h0001, 16'h1234};
        pts[0]  = '{16'h00F0, 16'h0F0F, 5'b01011, 2'b10, 3'b101};
        pts[1]  = '{16'hA5A5, 16'h5A5A, 5'b11111, 2'b01, 3'b010};
        pts[2]  = '{16'h0000, 16'hFFFF, 5'b00000, 2'b11, 3'b111};

        rst = 1'b1; start = 1'b0; opA = '0; opB = '0;
        pipe_A = '0; pipe_B = '0; pipe_Op = PIPE_OPC; pipe_sub_op = '0;
        pipe_Cin = 1'b0; pipe_nA = 1'b0; pipe_nB = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        rst = 1'b0;

        // Idle pass-through, same cycle
        for (int i = 0; i < 3; i++) begin
            pipe_A = pts[i].pa; pipe_B = pts[i].pb; pipe_Op = pts[i].op;
            pipe_sub_op = pts[i].sub;
            {pipe_Cin, pipe_nA, pipe_nB} = pts[i].ctl;
            #1;
            chk("pt A", 32'(alu_A), 32'(pts[i].pa));
            chk("pt B", 32'(alu_B), 32'(pts[i].pb));
            chk("pt Op", 32'(alu_Op), 32'(pts[i].op));
            chk("pt sub", 32'(alu_sub_op), 32'(pts[i].sub));
            chk("pt ctl", 32'({alu_Cin, alu_nA, alu_nB}), 32'(pts[i].ctl));
            chk("pt stall", 32'(stall), 32'd0);
            @(negedge clk);
        end
        pipe_A = 16'h00F0; pipe_B = 16'h0F00;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            chk("vec expect", 32'(prod(vecs[i].a, vecs[i].b)), 32'(vecs[i].exp));
            mul_op(vecs[i].a, vecs[i].b, 0, $sformatf("vec%0d", i));
        end

        // Start re-pulsed mid-operation is dropped
        mul_op(16'h0003, 16'h8005, 5, "repulse");

        // Reset mid-operation
        @(negedge clk);
        opA = 16'h1234; opB = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("midrst busy", 32'(stall), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst stall", 32'(stall), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst result", 32'(result), 32'd0);
        chk("midrst passA", 32'(alu_A), 32'(pipe_A));
        chk("midrst passOp", 32'(alu_Op), 32'(PIPE_OPC));
        rst = 1'b0;
        @(negedge clk);
        chk("postrst stall", 32'(stall), 32'd0);
        chk("postrst done", 32'(done), 32'd0);

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 4 == 1) rb = rb & 16'h000F;
            pipe_A = 16'($urandom);
            pipe_B = 16'($urandom);
            mul_op(ra, rb, 0, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
